// File: rtl/display_mem_arbiter.sv
// rtl/display_mem_arbiter.sv - video/core arbiter for the shared single-port text display memory
module display_mem_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int RD_LATENCY     = 1,
    parameter int VID_STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_VID     = 2'd1;
    localparam logic [1:0] ST_CORE    = 2'd2;
    localparam logic [3:0] STREAK_MAX = 4'(VID_STREAK_MAX);

    logic [1:0]            state;
    logic [3:0]            streak;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_vid;
    logic                  s0_vld;
    logic                  s0_vid;

    // Video wins unless it has already taken STREAK_MAX contended slots in a row.
    always_comb begin
        core_gnt = 1'b0;
        vid_gnt  = 1'b0;
        if (!reset) begin
            if (vid_req && !(core_req && streak == STREAK_MAX))
                vid_gnt = 1'b1;
            else if (core_req)
                core_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else if (vid_gnt)
            state <= ST_VID;
        else if (core_gnt)
            state <= ST_CORE;
        else
            state <= ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            streak <= 4'd0;
        else if (!core_req || core_gnt)
            streak <= 4'd0;
        else if (vid_gnt && streak != STREAK_MAX)
            streak <= streak + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (vid_gnt) begin
            mem_addr  <= vid_addr;
            mem_we    <= 1'b0;
        end else if (core_gnt) begin
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
            mem_we    <= core_we;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // The owner register doubles as stage 0 of the return tag pipeline; writes carry no tag.
    assign s0_vld = (state == ST_VID) || (state == ST_CORE && !mem_we);
    assign s0_vid = (state == ST_VID);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            tag_vid <= '0;
        end else begin
            tag_vld[0] <= s0_vld;
            tag_vid[0] <= s0_vid;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_vid[i] <= tag_vid[i-1];
            end
        end
    end

    assign core_rvalid = tag_vld[RD_LATENCY-1] & ~tag_vid[RD_LATENCY-1];
    assign vid_rvalid  = tag_vld[RD_LATENCY-1] &  tag_vid[RD_LATENCY-1];
    assign core_rdata  = mem_rdata;
    assign vid_rdata   = mem_rdata;
endmodule

// File: tb/tb_display_mem_arbiter.sv
// tb/tb_display_mem_arbiter.sv - directed-vector bench for display_mem_arbiter
module tb_display_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;

    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [15:0] core_addr, core_wdata, core_rdata;
    logic        vid_req, vid_gnt, vid_rvalid;
    logic [15:0] vid_addr, vid_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic        b_core_req, b_core_gnt, b_core_rvalid;
    logic [15:0] b_core_addr, b_core_rdata;
    logic        b_vid_req, b_vid_gnt, b_vid_rvalid;
    logic [15:0] b_vid_addr, b_vid_rdata;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we;
    logic        b_core_we = 1'b0;
    logic [15:0] b_core_wdata = 16'h0000;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    display_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    display_mem_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr), .core_wdata(b_core_wdata),
        .core_gnt(b_core_gnt), .core_rdata(b_core_rdata), .core_rvalid(b_core_rvalid),
        .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_gnt(b_vid_gnt),
        .vid_rdata(b_vid_rdata), .vid_rvalid(b_vid_rvalid),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [15:0] memval(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    // Memory models: latency 1 with a single remembered write, and latency 3 read-only.
    logic        wr_vld;
    logic [15:0] wr_a, wr_d, rd_q;
    logic [15:0] p3_0, p3_1, p3_2;

    always @(posedge clk) begin
        if (reset) wr_vld <= 1'b0;
        else if (mem_we) begin
            wr_vld <= 1'b1;
            wr_a   <= mem_addr;
            wr_d   <= mem_wdata;
        end
        rd_q <= (wr_vld && wr_a == mem_addr) ? wr_d : memval(mem_addr);
        p3_0 <= memval(b_mem_addr);
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rdata   = rd_q;
    assign b_mem_rdata = p3_2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ec, ev;
        reset = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0011; core_wdata = 16'h0000;
        vid_req = 1'b1; vid_addr = 16'h0022;
        b_core_req = 1'b0; b_core_addr = 16'h0000; b_vid_req = 1'b0; b_vid_addr = 16'h0000;

        // reset state
        tick(); tick(); #1;
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_vid_gnt", vid_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid", {core_rvalid, vid_rvalid}, 0);
        reset = 1'b0; core_req = 1'b0; vid_req = 1'b0;
        tick(); tick();

        // core write then read
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0392; core_wdata = 16'h0341;
        #1;
        chk("wr_core_gnt", core_gnt, 1);
        chk("wr_vid_gnt", vid_gnt, 0);
        tick();
        core_we = 1'b0; #1;
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 16'h0392);
        chk("wr_mem_wdata", mem_wdata, 16'h0341);
        chk("rd_core_gnt", core_gnt, 1);
        tick();
        core_req = 1'b0; #1;
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 16'h0392);
        chk("wr_no_rvalid", {core_rvalid, vid_rvalid}, 0);
        tick();
        chk("rd_core_rvalid", core_rvalid, 1);
        chk("rd_core_rdata", core_rdata, 16'h0341);
        chk("rd_vid_rvalid", vid_rvalid, 0);
        tick();
        chk("rd_rvalid_pulse", core_rvalid, 0);
        tick();

        // video streaming 0..7
        for (int k = 0; k < 12; k++) begin
            vid_req = (k < 8); vid_addr = 16'(k);
            #1;
            if (k < 8) begin
                chk("vs_vid_gnt", vid_gnt, 1);
                chk("vs_core_gnt", core_gnt, 0);
            end
            chk("vs_vid_rvalid", vid_rvalid, (k >= 2 && k < 10));
            chk("vs_core_rvalid", core_rvalid, 0);
            if (k >= 2 && k < 10) chk("vs_vid_rdata", vid_rdata, memval(16'(k - 2)));
            tick();
        end

        // both requesting: V V V V C repeating
        for (int k = 0; k < 12; k++) begin
            core_req = (k < 10); core_we = 1'b0; core_addr = 16'h0100;
            vid_req = (k < 10); vid_addr = 16'h0200 + 16'(k);
            #1;
            ec = (k % 5 == 4);
            if (k < 10) begin
                chk("st_core_gnt", core_gnt, ec);
                chk("st_vid_gnt", vid_gnt, !ec);
            end
            if (k >= 2) begin
                ev = ((k - 2) % 5 == 4);
                chk("st_core_rvalid", core_rvalid, ev);
                chk("st_vid_rvalid", vid_rvalid, !ev);
            end else begin
                chk("st_idle_rvalid", {core_rvalid, vid_rvalid}, 0);
            end
            tick();
        end

        // core drops req after one streak grant: streak restarts
        for (int k = 0; k < 7; k++) begin
            core_req = (k != 1); vid_req = 1'b1; vid_addr = 16'h0300 + 16'(k);
            #1;
            chk("sc_vid_gnt", vid_gnt, (k != 6));
            chk("sc_core_gnt", core_gnt, (k == 6));
            tick();
        end
        core_req = 1'b0; vid_req = 1'b0;
        tick(); tick(); tick();

        // reset in the middle of two reads
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0392;
        #1; chk("mr_core_gnt", core_gnt, 1);
        tick();
        core_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h0005;
        #1; chk("mr_vid_gnt", vid_gnt, 1);
        reset = 1'b1;
        #1;
        chk("mr_gnt_forced", {core_gnt, vid_gnt}, 0);
        chk("mr_mem_we", mem_we, 0);
        chk("mr_mem_addr", mem_addr, 0);
        tick();
        chk("mr_hold_addr", mem_addr, 0);
        chk("mr_hold_rvalid", {core_rvalid, vid_rvalid}, 0);
        reset = 1'b0; vid_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_rvalid", {core_rvalid, vid_rvalid}, 0);
        end

        // RD_LATENCY = 3, alternating video/core reads
        for (int k = 0; k < 14; k++) begin
            b_vid_req = (k < 8) && (k % 2 == 0); b_vid_addr = 16'h0040 + 16'(k);
            b_core_req = (k < 8) && (k % 2 == 1); b_core_addr = 16'h0080 + 16'(k);
            #1;
            if (k < 8) begin
                chk("l3_vid_gnt", b_vid_gnt, (k % 2 == 0));
                chk("l3_core_gnt", b_core_gnt, (k % 2 == 1));
            end
            if (k >= 4 && k < 12) begin
                chk("l3_vid_rvalid", b_vid_rvalid, (k % 2 == 0));
                chk("l3_core_rvalid", b_core_rvalid, (k % 2 == 1));
                if (k % 2 == 0) chk("l3_vid_rdata", b_vid_rdata, memval(16'h0040 + 16'(k - 4)));
                else chk("l3_core_rdata", b_core_rdata, memval(16'h0080 + 16'(k - 4)));
            end else begin
                chk("l3_idle_rvalid", {b_core_rvalid, b_vid_rvalid}, 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
